button_pattern_ctrl: RTL and testbench
======================================

# button_pattern_ctrl

Sequencing controller between the two debounced push-button channels (HIGH button = logic 1, LOW button = logic 0) and the pattern-detection datapath. It arbitrates the two buttons into a single serial bit stream, accepting one bit per press. It shifts accepted bits into a history register and detects a programmable pattern, overlapping occurrences included. On a match it drives a timed indicator output.

## Interface
Parameters:
- PAT_LEN, 4, pattern length in bits (2..8)
- PATTERN, 4'b1011, target sequence; MSB is the oldest bit, LSB the newest
- HOLD_CYCLES, 16'd50000, match_led on-time in sysclock cycles (1..65535; 0 is illegal)

Ports:
- sysclock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clean_btn  in  2  debounced buttons, already synchronous to sysclock; [1] = HIGH button, [0] = LOW button
- bit_valid  out  1  one-cycle pulse: a bit was accepted
- bit_value  out  1  value of the last accepted bit
- history  out  PAT_LEN  last PAT_LEN accepted bits; LSB is the newest
- bit_count  out  4  accepted-bit count, saturating at PAT_LEN
- match  out  1  one-cycle pulse: history equals PATTERN
- match_led  out  1  high for HOLD_CYCLES cycles after the most recent match
- conflict  out  1  one-cycle pulse: both buttons pressed in the same cycle while idle

## Operation
- FSM states: IDLE and WAIT_RELEASE. The reset state is WAIT_RELEASE, so a button held through reset is never accepted.
- In IDLE, the controller samples clean_btn every cycle:
  - 2'b10: accept bit 1, then go to WAIT_RELEASE.
  - 2'b01: accept bit 0, then go to WAIT_RELEASE.
  - 2'b11: no bit; pulse conflict; go to WAIT_RELEASE.
  - 2'b00: stay in IDLE.
- In WAIT_RELEASE, the controller stays until clean_btn == 2'b00, then goes to IDLE. Presses of the other button while one is held are ignored. Exactly one bit is accepted per press episode.
- On accept:
  - history <= {history[PAT_LEN-2:0], bit}
  - bit_value <= bit
  - bit_count <= min(bit_count+1, PAT_LEN)
  - bit_valid pulses
- Match rule: match pulses when the post-shift history == PATTERN and the post-shift bit_count == PAT_LEN. Detection is overlapping: no history clear on match.
- Hold timer (16-bit down-counter):
  - On match, load HOLD_CYCLES-1 and set match_led.
  - While match_led is high and the counter is nonzero, decrement.
  - At counter == 0 with no new match, clear match_led.
  - A match during the hold reloads the counter, extending the hold.
- Reset (any time, including mid-hold or mid-press) immediately zeroes all registered state.

## Timing
- All outputs are registered. Reset values are 0 for: bit_valid, bit_value, history, bit_count, match, match_led, conflict, and the hold counter.
- Accept latency: clean_btn is sampled at edge k in IDLE. At that edge, bit_valid, history, bit_count and bit_value update, and match is evaluated on the new history. All are visible in the cycle following edge k.
- match is coincident with its bit_valid pulse.
- conflict pulses in the same cycle position that bit_valid would have occupied.
- match_led rises with match and stays high for exactly HOLD_CYCLES cycles, absent a retrigger.
- Minimum press-to-press spacing: release must be seen for 1 cycle in WAIT_RELEASE, then 1 cycle in IDLE before the next accept. A new bit can therefore be accepted no earlier than 2 cycles after clean_btn returns to 00.
- bit_valid and conflict are never both high.
- match_led counter boundary: with HOLD_CYCLES = 1, match_led is high for exactly one cycle.

## Test plan
- Reset with clean_btn = 2'b10 held, release reset_n, keep the button held 10 cycles, then release -> no bit_valid; history = 0, bit_count = 0. The next press of 2'b10 is accepted.
- Defaults with HOLD_CYCLES = 8: presses 1,0,1,1 -> bit_valid ×4, history = 4'b1011, bit_count = 4. match pulses with the 4th bit_valid. match_led is high exactly 8 cycles.
- Overlap: presses 1,0,1,1,0,1,1 -> match on the 4th and 7th accepted bits. The 7th match occurs while match_led is still high and reloads the timer; match_led stays high continuously and falls 8 cycles after the second match.
- Conflict: clean_btn = 2'b11 from IDLE -> conflict pulse 1 cycle, no bit_valid, history unchanged. Still no accept until clean_btn returns to 00 and a single button is pressed.
- Cross-press: hold 2'b10, then change to 2'b11, then 2'b01, then 00 -> exactly one bit (value 1) accepted.
- Short sequence: presses 1,1 only -> bit_count = 2, no match, even though the history LSBs equal the pattern tail. Assert reset_n low mid-hold -> match_led = 0 immediately.

Source files
------------

// File: rtl/button_pattern_ctrl.sv
// Two-button serial bit entry with overlapping pattern detection
// and a retriggerable match indicator.
module button_pattern_ctrl #(
  parameter int unsigned        PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1011,
  parameter logic [15:0]        HOLD_CYCLES = 16'd50000
) (
  input  logic               sysclock,
  input  logic               reset_n,
  input  logic [1:0]         clean_btn,
  output logic               bit_valid,
  output logic               bit_value,
  output logic [PAT_LEN-1:0] history,
  output logic [3:0]         bit_count,
  output logic               match,
  output logic               match_led,
  output logic               conflict
);

  typedef enum logic {
    IDLE,
    WAIT_RELEASE
  } state_e;

  localparam logic [3:0] FULL = 4'(PAT_LEN);

  state_e             state_q, state_d;
  logic               bit_valid_q, bit_valid_d;
  logic               bit_value_q, bit_value_d;
  logic [PAT_LEN-1:0] history_q, history_d;
  logic [3:0]         bit_count_q, bit_count_d;
  logic               match_q, match_d;
  logic               led_q, led_d;
  logic [15:0]        hold_q, hold_d;
  logic               conflict_q, conflict_d;
  logic               accept;
  logic               acc_bit;

  always_comb begin
    state_d     = state_q;
    bit_valid_d = 1'b0;
    conflict_d  = 1'b0;
    match_d     = 1'b0;
    bit_value_d = bit_value_q;
    history_d   = history_q;
    bit_count_d = bit_count_q;
    led_d       = led_q;
    hold_d      = hold_q;
    accept      = 1'b0;
    acc_bit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (clean_btn == 2'b10): begin
            accept  = 1'b1;
            acc_bit = 1'b1;
            state_d = WAIT_RELEASE;
          end
          (clean_btn == 2'b01): begin
            accept  = 1'b1;
            state_d = WAIT_RELEASE;
          end
          (clean_btn == 2'b11): begin
            conflict_d = 1'b1;
            state_d    = WAIT_RELEASE;
          end
          default: ;
        endcase
      end
      WAIT_RELEASE: begin
        if (clean_btn == 2'b00)
          state_d = IDLE;
      end
      default: state_d = WAIT_RELEASE;
    endcase

    if (accept) begin
      history_d   = {history_q[PAT_LEN-2:0], acc_bit};
      bit_value_d = acc_bit;
      bit_valid_d = 1'b1;
      if (bit_count_q < FULL)
        bit_count_d = bit_count_q + 4'd1;
      match_d = (history_d == PATTERN) &&
                (bit_count_d == FULL);
    end

    // a match always (re)loads, so overlapping hits extend the hold
    if (match_d) begin
      hold_d = HOLD_CYCLES - 16'd1;
      led_d  = 1'b1;
    end else if (led_q) begin
      if (hold_q != 16'd0)
        hold_d = hold_q - 16'd1;
      else
        led_d = 1'b0;
    end
  end

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_RELEASE;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      history_q   <= '0;
      bit_count_q <= 4'd0;
      match_q     <= 1'b0;
      led_q       <= 1'b0;
      hold_q      <= 16'd0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      history_q   <= history_d;
      bit_count_q <= bit_count_d;
      match_q     <= match_d;
      led_q       <= led_d;
      hold_q      <= hold_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign history   = history_q;
  assign bit_count = bit_count_q;
  assign match     = match_q;
  assign match_led = led_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_button_pattern_ctrl.sv
// Directed bench: HOLD_CYCLES=8 main instance plus a HOLD_CYCLES=1
// instance sharing the same stimulus for the hold boundary.
module tb_button_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn = 2'b00;

  logic       bv, val, m, led, conf;
  logic [3:0] hist, cnt;
  logic       bv1, val1, m1, led1, conf1;
  logic [3:0] hist1, cnt1;

  int nvec = 0;
  int nerr = 0;

  logic       s_bv, s_val, s_m, s_led, s_led1, s_conf;
  logic [3:0] s_hist, s_cnt;
  logic       r_bv, r_led, r_led1;

  button_pattern_ctrl #(
    .PAT_LEN(4), .PATTERN(4'b1011), .HOLD_CYCLES(16'd8)
  ) dut (
    .sysclock(clk), .reset_n(rst_n), .clean_btn(btn),
    .bit_valid(bv), .bit_value(val), .history(hist),
    .bit_count(cnt), .match(m), .match_led(led),
    .conflict(conf)
  );

  button_pattern_ctrl #(
    .PAT_LEN(4), .PATTERN(4'b1011), .HOLD_CYCLES(16'd1)
  ) dut1 (
    .sysclock(clk), .reset_n(rst_n), .clean_btn(btn),
    .bit_valid(bv1), .bit_value(val1), .history(hist1),
    .bit_count(cnt1), .match(m1), .match_led(led1),
    .conflict(conf1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    btn = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic press(input logic [1:0] v);
    btn = v;
    tick();
    s_bv = bv; s_val = val; s_hist = hist; s_cnt = cnt;
    s_m = m; s_led = led; s_led1 = led1; s_conf = conf;
    btn = 2'b00;
    tick();
    r_bv = bv; r_led = led; r_led1 = led1;
  endtask

  task automatic measure_led(input int already, output int n);
    n = already;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (led) n++;
      else break;
    end
  endtask

  initial begin
    int nbv;
    int nled;
    logic seq [7];
    logic [3:0] mh;

    // button held through reset must not be accepted
    btn = 2'b10;
    rst_n = 1'b0;
    tick();
    chk("rst_bv", {15'd0, bv}, 16'd0);
    chk("rst_hist", {12'd0, hist}, 16'd0);
    chk("rst_cnt", {12'd0, cnt}, 16'd0);
    chk("rst_led", {15'd0, led}, 16'd0);
    chk("rst_misc", {12'd0, val, m, conf, led1}, 16'd0);
    rst_n = 1'b1;
    nbv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bv) nbv++;
    end
    btn = 2'b00;
    tick();
    chk("held_nbv", 16'(nbv), 16'd0);
    chk("held_hist", {12'd0, hist}, 16'd0);
    chk("held_cnt", {12'd0, cnt}, 16'd0);
    press(2'b10);
    chk("after_bv", {15'd0, s_bv}, 16'd1);
    chk("after_val", {15'd0, s_val}, 16'd1);
    chk("after_hist", {12'd0, s_hist}, 16'h1);
    chk("after_cnt", {12'd0, s_cnt}, 16'd1);
    chk("after_bv_drop", {15'd0, r_bv}, 16'd0);

    // basic 1,0,1,1 match and hold lengths
    do_reset();
    press(2'b10);
    chk("b1_m", {15'd0, s_m}, 16'd0);
    press(2'b01);
    chk("b2_val", {15'd0, s_val}, 16'd0);
    chk("b2_hist", {12'd0, s_hist}, 16'h2);
    press(2'b10);
    chk("b3_cnt", {12'd0, s_cnt}, 16'd3);
    chk("b3_m", {15'd0, s_m}, 16'd0);
    press(2'b10);
    chk("b4_bv", {15'd0, s_bv}, 16'd1);
    chk("b4_hist", {12'd0, s_hist}, 16'hb);
    chk("b4_cnt", {12'd0, s_cnt}, 16'd4);
    chk("b4_match", {15'd0, s_m}, 16'd1);
    chk("b4_led", {15'd0, s_led}, 16'd1);
    chk("b4_led1_on", {15'd0, s_led1}, 16'd1);
    chk("b4_led1_off", {15'd0, r_led1}, 16'd0);
    measure_led(2, nled);
    chk("b4_led_len", 16'(nled), 16'd8);

    // overlapping matches; second retriggers the hold
    do_reset();
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    mh = 4'd0;
    for (int i = 0; i < 7; i++) begin
      press(seq[i] ? 2'b10 : 2'b01);
      mh = {mh[2:0], seq[i]};
      chk($sformatf("ov%0d_hist", i), {12'd0, s_hist}, {12'd0, mh});
      chk($sformatf("ov%0d_match", i), {15'd0, s_m},
          (i == 3 || i == 6) ? 16'd1 : 16'd0);
      if (i >= 4)
        chk($sformatf("ov%0d_led", i), {14'd0, s_led, r_led}, 16'd3);
    end
    chk("ov_cnt", {12'd0, cnt}, 16'd4);
    measure_led(2, nled);
    chk("ov_led_len", 16'(nled), 16'd8);

    // conflict from idle, then ignored until release
    btn = 2'b11;
    tick();
    chk("cf_conf", {15'd0, conf}, 16'd1);
    chk("cf_bv", {15'd0, bv}, 16'd0);
    chk("cf_hist", {12'd0, hist}, 16'hb);
    btn = 2'b10;
    tick();
    chk("cf_hold", {14'd0, bv, conf}, 16'd0);
    btn = 2'b01;
    tick();
    chk("cf_hold2", {14'd0, bv, conf}, 16'd0);
    btn = 2'b00;
    tick();
    btn = 2'b01;
    tick();
    chk("cf_next_bv", {15'd0, bv}, 16'd1);
    chk("cf_next_hist", {12'd0, hist}, 16'h6);
    btn = 2'b00;
    tick();

    // cross press: exactly one bit, value 1
    nbv = 0;
    btn = 2'b10; tick(); nbv += int'(bv);
    btn = 2'b11; tick(); nbv += int'(bv);
    chk("x_conf", {15'd0, conf}, 16'd0);
    btn = 2'b01; tick(); nbv += int'(bv);
    btn = 2'b00; tick(); nbv += int'(bv);
    tick(); nbv += int'(bv);
    chk("x_nbv", 16'(nbv), 16'd1);
    chk("x_val", {15'd0, val}, 16'd1);
    chk("x_hist", {12'd0, hist}, 16'hd);

    // short sequence, then reset in the middle of a hold
    do_reset();
    press(2'b10);
    press(2'b10);
    chk("sh_cnt", {12'd0, s_cnt}, 16'd2);
    chk("sh_hist", {12'd0, s_hist}, 16'h3);
    chk("sh_match", {15'd0, s_m}, 16'd0);
    chk("sh_led", {15'd0, r_led}, 16'd0);
    press(2'b01);
    press(2'b10);
    press(2'b10);
    chk("sh5_match", {15'd0, s_m}, 16'd1);
    chk("sh5_hist", {12'd0, s_hist}, 16'hb);
    tick();
    chk("mid_led", {15'd0, led}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {15'd0, led}, 16'd0);
    chk("mid_rst_hist", {12'd0, hist}, 16'd0);
    chk("mid_rst_cnt", {12'd0, cnt}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
